uart_instr_loader: RTL
======================

// Module: uart_instr_loader
// PURPOSE
//  Boot-time loader that replaces the $readmemh preload of instr_mem.
//  - Receives a program image as UART bytes and assembles them into DATA_WIDTH words.
//  - Writes each word into the instruction memory.
//  - Holds the CPU in reset until the image is complete.
//  Sits between the UART receiver and the bus / instr_mem write port.
//  With uart_on low it is transparent: the CPU runs from the preloaded image.
// PARAMETERS
//  DATA_WIDTH      32      instruction word width; multiple of 8
//  ADDR_WIDTH      8       word-address width; memory depth = 2**ADDR_WIDTH
//  BASE_ADDR       0       word address of the first loaded word
//  BIG_ENDIAN      1       1: first byte of a word is its MSB; 0: first byte is its LSB
//  TIMEOUT_CYCLES  100000  maximum clk cycles allowed between bytes once a load has begun
// PORTS
//  clk        in   1           system clock, single domain
//  reset      in   1           asynchronous, active-high
//  uart_on    in   1           1 = load via UART; 0 = bypass
//  rx_data    in   8           received byte
//  rx_valid   in   1           one-cycle strobe: rx_data is valid
//  mem_we     out  1           instr_mem write enable, one-cycle pulse
//  mem_addr   out  ADDR_WIDTH  word address
//  mem_wdata  out  DATA_WIDTH  word to write
//  cpu_hold   out  1           ORed into the CPU reset
//  done       out  1           image loaded successfully
//  error      out  1           load failed (oversize image or timeout)
// BEHAVIOUR
//  Reset values
//  - Asynchronous reset forces state IDLE and clears every output and counter.
//  - Reset mid-load aborts the load; words already written are not rolled back.
//  Image format
//  - 2-byte word count N, MSB first, always big-endian.
//  - Then N words of DATA_WIDTH/8 bytes each, byte order set by BIG_ENDIAN.
//  States
//  - IDLE: cpu_hold=0. uart_on=1 -> LEN, cpu_hold=1 from the next cycle.
//  - LEN: capture the 2 count bytes.
//      N==0 -> DONE.
//      N > 2**ADDR_WIDTH-BASE_ADDR -> ERR.
//      Otherwise -> DATA, word index cleared.
//  - DATA: shift in bytes.
//      On the last byte of a word, mem_we pulses on the NEXT cycle (registered).
//      mem_addr = BASE_ADDR + index; index then increments.
//      A new rx_valid in the mem_we cycle is accepted normally, so there is no dead cycle.
//      After word N is written -> DONE in the same cycle as its mem_we pulse.
//  - DONE: done=1, cpu_hold=0. Stays here while uart_on=1; uart_on=0 -> IDLE.
//  - ERR: error=1, cpu_hold stays 1. uart_on=0 -> IDLE.
//  Timeout
//  - The counter starts at the first LEN byte and clears on every rx_valid.
//  - At TIMEOUT_CYCLES-1 with no byte -> ERR.
//  - There is no timeout while waiting for the first byte.
//  uart_on
//  - uart_on=0 in LEN or DATA aborts to IDLE; cpu_hold releases the next cycle.
//  - Bytes received in IDLE, DONE or ERR are ignored.
//  - mem_addr and mem_wdata hold their last values between pulses.
//  - The word index is ADDR_WIDTH+1 bits wide, so the full-depth case N == 2**ADDR_WIDTH is legal.
// STRUCTURE
//  - loader_defs.vh: state encodings (IDLE, LEN, DATA, DONE, ERR) and LEN_BYTES=2.
//  - Sub-module byte_assembler (params DATA_WIDTH, BIG_ENDIAN):
//      shifts bytes into a word, counts bytes, outputs word_valid and word.
//  - Top level: FSM, word index, timeout counter, registered memory write.
// TESTING
//  - Basic load: uart_on=1, bytes 00 02 | 12 34 56 78 | 9A BC DE F0 ->
//      mem_we at addr 0 (wdata 0x12345678), then addr 1 (wdata 0x9ABCDEF0).
//      done=1 and cpu_hold=0 the cycle after the second write.
//  - Byte order: BIG_ENDIAN=0, BASE_ADDR=4, bytes 00 01 78 56 34 12 ->
//      single write at addr 4, wdata 0x12345678.
//  - Zero length: bytes 00 00 -> DONE with no mem_we pulse.
//  - Oversize: ADDR_WIDTH=8, count 01 01 (N=257) -> error=1, cpu_hold=1, no mem_we.
//      Dropping uart_on -> IDLE.
//  - Timeout and abort: TIMEOUT_CYCLES=50, stall 50 cycles after 3 data bytes -> error=1.
//      Separately, uart_on dropped mid-word -> IDLE, cpu_hold=0, no write of the partial word.
//  - Bypass and reset: uart_on=0 with rx_valid toggling -> no mem_we and cpu_hold=0.
//      reset asserted mid-DATA -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/uart_instr_loader_pkg.sv
// Shared types and constants for the UART instruction loader.
package uart_instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // The image header is a big-endian 16-bit word count.
  localparam int LEN_BYTES = 2;

endpackage

// File: rtl/uart_instr_loader_byte_assembler.sv
// Packs a stream of bytes into DATA_WIDTH words. word carries the completed
// word combinationally in the cycle word_valid is high (the last byte's cycle).
module uart_instr_loader_byte_assembler #(
  parameter int DATA_WIDTH = 32,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES) + 1;

  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] byte_ext;
  logic [CW-1:0]         count;

  assign byte_ext   = DATA_WIDTH'(byte_data);
  assign word_valid = byte_valid && (count == CW'(BYTES - 1));

  // Next shift-register value: new byte enters at the LSB (big-endian) or MSB (little-endian).
  always_comb begin
    if (BIG_ENDIAN != 0) word = (shift << 8) | byte_ext;
    else                 word = (shift >> 8) | (byte_ext << (DATA_WIDTH - 8));
  end

  // Byte counter and shift register; a completed word restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift <= '0;
      count <= '0;
    end else if (clear) begin
      shift <= '0;
      count <= '0;
    end else if (byte_valid) begin
      shift <= word;
      count <= word_valid ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_instr_loader.sv
// Boot loader: receives a length-prefixed program image over UART, writes it
// into instruction memory and holds the CPU in reset until it is complete.
module uart_instr_loader
  import uart_instr_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int BASE_ADDR      = 0,
  parameter int BIG_ENDIAN     = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_on,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW        = ADDR_WIDTH + 1;
  localparam int MAX_WORDS = (1 << ADDR_WIDTH) - BASE_ADDR;

  state_t                state, state_next;
  logic [1:0]            len_cnt;
  logic [7:0]            len_hi;
  logic [15:0]           len;
  logic [15:0]           count_n;
  logic                  len_last;
  logic [IW-1:0]         index;
  logic [TW-1:0]         tcnt;
  logic                  timing;
  logic                  timeout;
  logic                  all_written;
  logic                  asm_valid;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;

  assign count_n     = {len_hi, rx_data};
  assign len_last    = (len_cnt == 2'(LEN_BYTES - 1));
  assign all_written = (32'(index) == 32'(len));
  // The timer only runs once the first header byte has arrived.
  assign timing      = ((state == ST_LEN) && (len_cnt != 2'd0)) || (state == ST_DATA);
  assign timeout     = timing && !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  // Once all N words are written, stray bytes must not start another word.
  assign asm_valid   = rx_valid && uart_on && (state == ST_DATA) && !all_written;

  assign cpu_hold = (state == ST_LEN) || (state == ST_DATA) || (state == ST_ERR);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERR);

  uart_instr_loader_byte_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != ST_DATA),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; dropping uart_on always wins over progress or timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (uart_on) state_next = ST_LEN;
      ST_LEN: begin
        if (!uart_on) state_next = ST_IDLE;
        else if (rx_valid && len_last) begin
          if (count_n == 16'd0)                state_next = ST_DONE;
          else if (32'(count_n) > MAX_WORDS)   state_next = ST_ERR;
          else                                 state_next = ST_DATA;
        end else if (timeout) state_next = ST_ERR;
      end
      ST_DATA: begin
        if (!uart_on)                   state_next = ST_IDLE;
        else if (mem_we && all_written) state_next = ST_DONE;
        else if (timeout)               state_next = ST_ERR;
      end
      ST_DONE, ST_ERR: if (!uart_on) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Header capture, word index, inter-byte timer and registered memory write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_cnt   <= '0;
      len_hi    <= '0;
      len       <= '0;
      index     <= '0;
      tcnt      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= word_valid;
      if (word_valid) begin
        mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + index[ADDR_WIDTH-1:0];
        mem_wdata <= word;
        index     <= index + IW'(1);
      end else if (state != ST_DATA) begin
        index <= '0;
      end

      if (state == ST_LEN) begin
        if (rx_valid && uart_on) begin
          if (len_last) begin
            len     <= count_n;
            len_cnt <= '0;
          end else begin
            len_hi  <= rx_data;
            len_cnt <= len_cnt + 2'd1;
          end
        end
      end else begin
        len_cnt <= '0;
      end

      if (!timing || rx_valid) tcnt <= '0;
      else                     tcnt <= tcnt + TW'(1);
    end
  end

endmodule
